smart_home_sensor_if: RTL and testbench
=======================================

SMART_HOME_SENSOR_IF -- requirements
Module: smart_home_sensor_if

Interface
REQ-001 SHALL take parameter DEB_CYCLES, default 4: consecutive stable cycles needed before a debounced door/window/fire output changes; legal range 1..255.
REQ-002 SHALL take parameter SCLK_DIV, default 4: temp_sclk half-period in clk cycles; legal range 1..255.
REQ-003 SHALL take parameter CONV_PERIOD, default 1024: clk cycles between temperature conversion starts; legal only if CONV_PERIOD >= 18*SCLK_DIV+4.
REQ-004 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have ports raw_fd, raw_rd, raw_w, raw_fa  input  1 each  asynchronous contacts for front door, rear door, window and fire alarm.
REQ-007 SHALL have port temp_miso  input  1  serial data from the temperature sensor.
REQ-008 SHALL have ports temp_cs_n, temp_sclk  output  1 each  sensor chip select (active-low) and serial clock.
REQ-009 SHALL have ports SFD, SRD, SW, SFA  output  1 each  debounced sensor levels feeding the home controller.
REQ-010 SHALL have port ST  output  7  latest temperature in degrees C, unsigned.
REQ-011 SHALL have port st_valid  output  1  single-cycle pulse when ST updates.

Function
REQ-012 SHALL pass each raw_* input through its own 2-flop synchronizer before any other logic.
REQ-013 SHALL run one debounce counter per contact; the counter clears whenever the synchronized value equals the current output.
REQ-014 SHALL toggle a debounced output on the cycle its counter reaches DEB_CYCLES, then clear the counter; a glitch shorter than DEB_CYCLES cycles SHALL produce no output change.
REQ-015 SHALL give a raw edge a total latency of 2 + DEB_CYCLES cycles to the debounced output.
REQ-016 SHALL run a free-running period counter 0..CONV_PERIOD-1 that starts from 0 at reset release; it SHALL issue a start tick on the cycle it equals CONV_PERIOD-1.
REQ-017 SHALL implement a conversion FSM with states IDLE, SETUP, HIGH, LOW, DONE.
REQ-018 IDLE: temp_cs_n=1, temp_sclk=0; on a start tick go to SETUP next cycle.
REQ-019 SETUP: temp_cs_n=0, temp_sclk=0; hold for SCLK_DIV cycles, then go to HIGH.
REQ-020 HIGH: temp_sclk=1 for SCLK_DIV cycles; sample temp_miso on the first HIGH cycle into an 8-bit shift register, MSB first.
REQ-021 LOW: temp_sclk=0 for SCLK_DIV cycles; after the 8th LOW phase go to DONE, otherwise return to HIGH.
REQ-022 DONE (1 cycle): temp_cs_n=1; load ST and pulse st_valid; return to IDLE.
REQ-023 Saturation: if the received frame has bit7=1, ST SHALL be 127; otherwise ST SHALL equal frame[6:0].
REQ-024 A start tick arriving while the FSM is not in IDLE SHALL be ignored; the period counter SHALL keep running.
REQ-025 ST SHALL hold its value between conversions; st_valid SHALL be 0 outside DONE.
REQ-026 Debounce and conversion paths SHALL run independently; simultaneous changes on all four contacts SHALL each resolve at the latency in REQ-015.

Reset
REQ-027 While Rst=1, regardless of clk: SFD=SRD=SW=SFA=0, ST=0, st_valid=0, temp_cs_n=1, temp_sclk=0, all counters and synchronizers 0, FSM in IDLE.
REQ-028 Rst asserted mid-frame SHALL abort the frame immediately with no ST update; the first frame after release starts at cycle CONV_PERIOD.

Verification
REQ-029 raw_fd rises and stays high, DEB_CYCLES=4 -> SFD=1 exactly 6 cycles after the first sampled high; a 3-cycle raw_fd pulse -> SFD stays 0.
REQ-030 temp_miso drives frame 0x19, SCLK_DIV=4 -> 8 temp_sclk pulses of 4 cycles high/4 cycles low; ST=25 with a single st_valid pulse; temp_cs_n low for exactly 4+64 cycles.
REQ-031 frame 0xC8 -> ST=127; frame 0x7F -> ST=127; frame 0x00 -> ST=0.
REQ-032 Rst pulsed during the 5th HIGH phase -> temp_cs_n=1 and temp_sclk=0 immediately, ST=0, no st_valid pulse; the next conversion starts CONV_PERIOD cycles after reset release.
REQ-033 raw_fd, raw_rd, raw_w, raw_fa all toggled on the same cycle -> all four debounced outputs change on the same cycle; conversions continue unaffected.

Source files
------------

// File: rtl/smart_home_sensor_if.sv
// Smart-home sensor front end: four debounced contacts and a serial temperature
// reader that samples the sensor every CONV_PERIOD cycles.

module smart_home_sensor_if_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES);

  logic [1:0] sync_q, sync_d;
  logic [7:0] cnt_q, cnt_d;
  logic       deb_q, deb_d;

  always_comb begin
    sync_d = {sync_q[0], raw};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    // Counter only runs while the synchronized level disagrees with the output.
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb = deb_q;
endmodule

module smart_home_sensor_if #(
  parameter int DEB_CYCLES  = 4,
  parameter int SCLK_DIV    = 4,
  parameter int CONV_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_w,
  input  logic       raw_fa,
  input  logic       temp_miso,
  output logic       temp_cs_n,
  output logic       temp_sclk,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [6:0] ST,
  output logic       st_valid
);
  localparam int         NUM_LANES = 4;
  localparam int         PW        = $clog2(CONV_PERIOD + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(CONV_PERIOD - 1);
  localparam logic [7:0] DIV_LAST  = 8'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  logic [NUM_LANES-1:0] raw_in, deb_out;

  assign raw_in = {raw_fa, raw_w, raw_rd, raw_fd};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      smart_home_sensor_if_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk (clk),
        .rst (Rst),
        .raw (raw_in[g]),
        .deb (deb_out[g])
      );
    end
  endgenerate

  assign SFD = deb_out[0];
  assign SRD = deb_out[1];
  assign SW  = deb_out[2];
  assign SFA = deb_out[3];

  state_t        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [7:0]    div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [6:0]    st_q, st_d;
  logic          tick;

  assign tick  = (per_q == PER_LAST);
  assign per_d = tick ? '0 : per_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    st_d      = st_q;
    temp_cs_n = 1'b1;
    temp_sclk = 1'b0;
    st_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (tick) state_d = SETUP;
      end
      SETUP: begin
        temp_cs_n = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HIGH: begin
        temp_cs_n = 1'b0;
        temp_sclk = 1'b1;
        if (div_q == 8'd0) sh_d = {sh_q[6:0], temp_miso};
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = LOW;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      LOW: begin
        temp_cs_n = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          // ST is loaded on entry to DONE so it is already valid while st_valid is high.
          if (bit_q == 3'd7) begin
            state_d = DONE;
            st_d    = sh_q[7] ? 7'h7F : sh_q[6:0];
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = HIGH;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        st_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      st_q    <= st_d;
    end
  end

  assign ST = st_q;
endmodule

// File: tb/tb_smart_home_sensor_if.sv
// Scoreboard bench: contact-level and sensor-level models push expectations,
// one monitor compares whenever the DUT shows a change or a valid result.

module tb_smart_home_sensor_if;
  localparam int DEB = 4;
  localparam int SD  = 4;
  localparam int P   = 100;

  logic       clk = 1'b0;
  logic       Rst;
  logic [3:0] raw;
  logic       temp_miso;
  logic       temp_cs_n, temp_sclk, SFD, SRD, SW, SFA, st_valid;
  logic [6:0] ST;

  smart_home_sensor_if #(.DEB_CYCLES(DEB), .SCLK_DIV(SD), .CONV_PERIOD(P)) dut (
    .clk(clk), .Rst(Rst),
    .raw_fd(raw[0]), .raw_rd(raw[1]), .raw_w(raw[2]), .raw_fa(raw[3]),
    .temp_miso(temp_miso), .temp_cs_n(temp_cs_n), .temp_sclk(temp_sclk),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST), .st_valid(st_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int dq [4][$];     // expected output changes per contact: 2*edge + value
  int exp_st[$];
  int frames[$];
  int rel_cyc = 0;
  int n_rise = 0;

  logic [3:0] mo;    // model debounced level
  logic [3:0] runv;  // value of current raw run
  int runst[4];      // edge where the current raw run was first sampled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // A raw level held for DEB+1 consecutive samples against the current
  // debounced level appears on the output two edges after the last sample.
  task automatic drive(input logic [3:0] v);
    int e;
    @(negedge clk);
    e = cyc + 1;
    for (int c = 0; c < 4; c++) begin
      if (v[c] !== runv[c]) begin
        runv[c]  = v[c];
        runst[c] = e;
      end
      if (v[c] !== mo[c] && (e - runst[c] + 1) == DEB + 1) begin
        dq[c].push_back(2 * (e + 2) + int'(v[c]));
        mo[c] = v[c];
      end
    end
    raw = v;
  endtask

  task automatic drive_n(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  // Sensor model: MSB on chip-select fall, next bit on each sclk fall.
  initial begin : sensor
    logic [7:0] f;
    temp_miso = 1'b0;
    forever begin
      @(negedge temp_cs_n);
      if (frames.size() > 0) f = 8'(frames.pop_front());
      else f = 8'($urandom_range(0, 255));
      exp_st.push_back(f[7] ? 127 : int'(f[6:0]));
      temp_miso = f[7];
      for (int i = 6; i >= 0; i--) begin
        @(negedge temp_sclk or posedge temp_cs_n);
        if (temp_cs_n) break;
        temp_miso = f[i];
      end
    end
  end

  // Monitor
  logic [3:0] dprev = '0;
  logic       cs_prev = 1'b1, sclk_prev = 1'b0, vld_prev = 1'b0;
  int         fall_cyc = 0, hi_len = 0, hi_bad = 0;

  always begin : monitor
    logic [3:0] dout;
    int x;
    @(posedge clk);
    #1;
    dout = {SFA, SW, SRD, SFD};
    if (Rst) begin
      dprev = '0; cs_prev = 1'b1; sclk_prev = 1'b0; vld_prev = 1'b0;
      n_rise = 0; hi_len = 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (dq[c].size() > 0 && dq[c][0] / 2 < cyc) begin
          x = dq[c].pop_front();
          fail_now($sformatf("deb_missed lane%0d edge %0d", c, x / 2));
        end
        if (dout[c] !== dprev[c]) begin
          if (dq[c].size() == 0) fail_now($sformatf("deb_unexpected lane%0d", c));
          else begin
            x = dq[c].pop_front();
            check($sformatf("deb_edge lane%0d", c), cyc, x / 2);
            check($sformatf("deb_val lane%0d", c), {31'd0, dout[c]}, x % 2);
          end
        end
      end
      dprev = dout;

      if (cs_prev && !temp_cs_n) begin
        check("conv_start_phase", (cyc - rel_cyc) % P, 0);
        fall_cyc = cyc; n_rise = 0; hi_bad = 0; hi_len = 0;
      end
      if (!cs_prev && temp_cs_n) begin
        check("cs_low_cycles", cyc - fall_cyc, 17 * SD);
        check("sclk_pulses", n_rise, 8);
        check("sclk_high_width_errs", hi_bad, 0);
      end
      if (temp_sclk) hi_len++;
      if (!sclk_prev && temp_sclk) n_rise++;
      if (sclk_prev && !temp_sclk) begin
        if (hi_len != SD) hi_bad++;
        hi_len = 0;
      end
      if (vld_prev) check("st_valid_single", {31'd0, st_valid}, 0);
      if (st_valid) begin
        if (exp_st.size() == 0) fail_now("st_valid_unexpected");
        else check("ST", {25'd0, ST}, exp_st.pop_front());
      end
      cs_prev = temp_cs_n; sclk_prev = temp_sclk; vld_prev = st_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rem[4];
    logic [3:0] nv;
    int k;
    Rst = 1'b1;
    raw = '0;
    mo = '0;
    runv = '0;
    for (int c = 0; c < 4; c++) runst[c] = -100;
    frames.push_back(8'h19);
    frames.push_back(8'hC8);
    frames.push_back(8'h7F);
    frames.push_back(8'h00);

    #1;
    check("rst_deb_outs", {28'd0, SFA, SW, SRD, SFD}, 0);
    check("rst_ST", {25'd0, ST}, 0);
    check("rst_st_valid", {31'd0, st_valid}, 0);
    check("rst_cs_n", {31'd0, temp_cs_n}, 1);
    check("rst_sclk", {31'd0, temp_sclk}, 0);

    repeat (3) @(negedge clk);
    Rst = 1'b0;
    rel_cyc = cyc;

    // Short front-door glitch, then a sustained level.
    drive_n(4'b0001, 3);
    drive_n(4'b0000, 8);
    drive_n(4'b0001, 12);
    drive_n(4'b0000, 12);

    // Independent random contact activity, mixing glitches and holds.
    nv = '0;
    for (int c = 0; c < 4; c++) rem[c] = 0;
    repeat (1200) begin
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          nv[c] = ~nv[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 15) : $urandom_range(1, 6);
        end
        rem[c]--;
      end
      drive(nv);
    end

    // All four contacts change together.
    drive_n(4'b0000, 12);
    drive_n(4'b1111, 12);
    drive_n(4'b0000, 12);

    // Reset in the middle of the 5th HIGH phase of a frame.
    k = 0;
    while (!(temp_cs_n === 1'b0 && n_rise == 5) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) fail_now("wait_5th_high_timeout");
    @(negedge clk);
    Rst = 1'b1;
    #1;
    check("midrst_cs_n", {31'd0, temp_cs_n}, 1);
    check("midrst_sclk", {31'd0, temp_sclk}, 0);
    check("midrst_ST", {25'd0, ST}, 0);
    check("midrst_st_valid", {31'd0, st_valid}, 0);
    exp_st.delete();
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    rel_cyc = cyc;

    repeat (3 * P + 80) @(negedge clk);
    for (int c = 0; c < 4; c++) check($sformatf("deb_pending lane%0d", c), dq[c].size(), 0);
    check("st_pending", exp_st.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
